coalesce_store_queue: RTL and testbench
=======================================

COALESCE_STORE_QUEUE -- requirements
Module: coalesce_store_queue

Interface
REQ-001 SHALL have parameter SQ_DEPTH, default 8, number of entries; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 32, physical address width.
REQ-003 SHALL have parameter DATA_W, default 32, word width; a multiple of 8, with STRB_W = DATA_W/8.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: flush_i  in  1  discard all uncommitted entries.
REQ-006 SHALL have ports: enq_valid_i in 1, enq_ready_o out 1, enq_addr_i in ADDR_W, enq_data_i in DATA_W, enq_strb_i in STRB_W, enq_uncached_i in 1; these carry the store entering at M1.
REQ-007 SHALL have ports: commit_i  in  1  retire the oldest uncommitted entry.
REQ-008 SHALL have ports: drain_valid_o out 1, drain_ready_i in 1, drain_addr_o out ADDR_W, drain_data_o out DATA_W, drain_strb_o out STRB_W, drain_uncached_o out 1; this is the committed-store write port toward the cache.
REQ-009 SHALL have ports: ld_addr_i in ADDR_W, ld_fwd_mask_o out STRB_W, ld_fwd_data_o out DATA_W, ld_conflict_o out 1; this is the load lookup.
REQ-010 SHALL have ports: full_o out 1, empty_o out 1, count_o out $clog2(SQ_DEPTH)+1.

Function
REQ-011 SHALL be a circular queue with three pointers, each one bit wider than the index: head (oldest entry), cmt (first uncommitted entry), tail (next free slot); invariant head <= cmt <= tail.
REQ-012 SHALL drive enq_ready_o = (count < SQ_DEPTH); the comparison uses the current count, so a drain in the same cycle does not free a slot for that cycle's enqueue.
REQ-013 SHALL, on enq_valid_i & enq_ready_o & !flush_i, write {addr, data, strb, uncached} at tail and increment tail; enq_strb_i == 0 SHALL still occupy an entry.
REQ-014 SHALL, on commit_i with cmt != tail, increment cmt; commit_i with cmt == tail SHALL be ignored.
REQ-015 SHALL drive drain_valid_o = (head != cmt); the drain_* data outputs SHALL show the head entry; drain fire = drain_valid_o & drain_ready_i SHALL increment head.
REQ-016 SHALL keep drain_* data stable while drain_valid_o & !drain_ready_i, including during flush_i.
REQ-017 SHALL, on flush_i, apply a same-cycle commit first and then set tail <= the updated cmt; the enqueue in that cycle is dropped; a same-cycle drain proceeds.
REQ-018 SHALL, for the lookup, compare word addresses addr[ADDR_W-1:$clog2(STRB_W)] against all valid entries in [head, tail), committed or not.
REQ-019 SHALL, for each byte b, select the youngest matching cacheable entry with strb[b] set; ld_fwd_mask_o[b] = 1 and ld_fwd_data_o byte b = that entry's byte. Unselected bytes SHALL read as 0.
REQ-020 SHALL assert ld_conflict_o when any matching entry has uncached set; such entries SHALL NOT contribute to the forward mask.
REQ-021 SHALL make the lookup purely combinational on registered storage; a store enqueued this cycle is invisible until the next cycle; the entry draining this cycle is still visible.
REQ-022 SHALL compute count_o = tail - head modulo 2*SQ_DEPTH, with full_o = (count_o == SQ_DEPTH) and empty_o = (count_o == 0), all registered-state derived.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear head, cmt and tail to 0; then enq_ready_o=1, drain_valid_o=0, empty_o=1, full_o=0, count_o=0, ld_fwd_mask_o=0, ld_conflict_o=0.
REQ-024 SHALL NOT reset the entry payload storage; drain_* data outputs are don't-care while drain_valid_o=0.

Configuration
REQ-025 SHALL support macro SQ_COALESCE_EN. When defined: an enqueue whose word address matches the youngest entry, where that entry is uncommitted, cacheable, and the incoming store is cacheable, SHALL merge into it (data bytes per enq_strb_i, strb OR-ed) and SHALL NOT advance tail; it is accepted even when full. The merged entry then absorbs one extra commit_i via a per-entry merge counter (width $clog2(SQ_DEPTH)+1); cmt advances only when that counter is exhausted.
REQ-026 SHALL, when SQ_COALESCE_EN is not defined, never merge: every enqueue allocates a new entry and the merge counter logic is absent.

Structure
REQ-027 SHALL place sq_entry_t (addr, data, strb, uncached, merge_cnt) and the SQ_DEPTH/DATA_W defaults in the shared package with the other lsu typedefs.
REQ-028 SHALL implement the per-byte youngest-match priority selection in one sub-module, sq_fwd_select, instantiated STRB_W times.

Verification
REQ-029 SHALL cover: enqueue 8 stores on reset, no commit -> full_o=1, enq_ready_o=0, drain_valid_o=0; then 3 commit_i pulses -> drain emits exactly 3 entries in order.
REQ-030 SHALL cover: store 0x1000 data 0xAABBCCDD strb 0xF, then 0x1002 data 0x11220000 strb 0xC; lookup 0x1000 -> mask 0xF, data 0x1122CCDD.
REQ-031 SHALL cover: 5 entries with 2 committed, then flush_i together with commit_i -> count_o=3, 3 drains, then empty_o=1.
REQ-032 SHALL cover: uncached store to 0x2000; lookup 0x2004 -> conflict 0, mask 0; lookup 0x2000 -> ld_conflict_o=1, mask 0.
REQ-033 SHALL cover: drain_ready_i held 0 for 4 cycles with flush_i pulsed -> drain_* stable, and the head entry is emitted once drain_ready_i rises.
REQ-034 SHALL cover, with SQ_COALESCE_EN defined: two cacheable stores to 0x3000 strb 0x3 then 0xC -> count_o=1, strb 0xF; two commit_i pulses are needed before drain_valid_o=1.

Source files
------------

// File: rtl/coalesce_store_queue_pkg.sv
// Shared lsu store-queue types: default geometry and the queue entry layout.
package coalesce_store_queue_pkg;

  localparam int unsigned SQ_DEPTH_DEF = 8;
  localparam int unsigned SQ_ADDR_W    = 32;
  localparam int unsigned SQ_DATA_W    = 32;
  localparam int unsigned SQ_STRB_W    = SQ_DATA_W / 8;
  localparam int unsigned SQ_CNT_W     = $clog2(SQ_DEPTH_DEF) + 1;

  // One buffered store. merge_cnt counts extra commits owed by coalesced stores.
  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    logic [SQ_STRB_W-1:0] strb;
    logic                 uncached;
    logic [SQ_CNT_W-1:0]  merge_cnt;
  } sq_entry_t;

endpackage

// File: rtl/coalesce_store_queue_sq_fwd_select.sv
// Per-byte forwarding select: picks the youngest hitting entry's byte.
// Inputs are ordered oldest (index 0) to youngest (index DEPTH-1).
module sq_fwd_select #(
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH-1:0]   hit_i,
  input  logic [DEPTH*8-1:0] data_i,
  output logic               sel_o,
  output logic [7:0]         byte_o
);

  // Later (younger) hits override earlier ones; no hit reads as zero.
  always_comb begin
    sel_o  = 1'b0;
    byte_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (hit_i[k]) begin
        sel_o  = 1'b1;
        byte_o = data_i[k*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/coalesce_store_queue.sv
// Store queue with commit/drain split and byte-granular load forwarding.
// Optional same-word store coalescing into the youngest entry: SQ_COALESCE_EN.
module coalesce_store_queue
  import coalesce_store_queue_pkg::*;
#(
  parameter int unsigned SQ_DEPTH = SQ_DEPTH_DEF,
  parameter int unsigned ADDR_W   = SQ_ADDR_W,
  parameter int unsigned DATA_W   = SQ_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [ADDR_W-1:0]          enq_addr_i,
  input  logic [DATA_W-1:0]          enq_data_i,
  input  logic [DATA_W/8-1:0]        enq_strb_i,
  input  logic                       enq_uncached_i,
  input  logic                       commit_i,
  output logic                       drain_valid_o,
  input  logic                       drain_ready_i,
  output logic [ADDR_W-1:0]          drain_addr_o,
  output logic [DATA_W-1:0]          drain_data_o,
  output logic [DATA_W/8-1:0]        drain_strb_o,
  output logic                       drain_uncached_o,
  input  logic [ADDR_W-1:0]          ld_addr_i,
  output logic [DATA_W/8-1:0]        ld_fwd_mask_o,
  output logic [DATA_W-1:0]          ld_fwd_data_o,
  output logic                       ld_conflict_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(SQ_DEPTH):0]  count_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(SQ_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  logic [PTR_W-1:0] head_q, cmt_q, tail_q, cmt_next, count;
  sq_entry_t        mem_q [SQ_DEPTH];

  logic has_room, commit_ok, commit_adv, merge, enq_fire, alloc, drain_fire;

  assign count     = tail_q - head_q;
  assign has_room  = count < PTR_W'(SQ_DEPTH);
  assign commit_ok = commit_i & (cmt_q != tail_q);

`ifdef SQ_COALESCE_EN
  logic [IDX_W-1:0] cmt_idx, yng_idx;
  sq_entry_t        yng;
  logic             commit_dec;

  assign cmt_idx    = cmt_q[IDX_W-1:0];
  assign yng_idx    = IDX_W'(tail_q - PTR_W'(1));
  assign yng        = mem_q[yng_idx];
  assign commit_adv = commit_ok & (mem_q[cmt_idx].merge_cnt == '0);
  assign commit_dec = commit_ok & ~commit_adv;
  // Never merge into an entry that this same cycle's commit retires, nor past counter saturation.
  assign merge = (cmt_q != tail_q) & ~yng.uncached & ~enq_uncached_i
               & (yng.addr[ADDR_W-1:OFF_W] == enq_addr_i[ADDR_W-1:OFF_W])
               & (yng.merge_cnt != '1)
               & ~(commit_adv & ((cmt_q + PTR_W'(1)) == tail_q));
  assign enq_ready_o = has_room | merge;
`else
  assign commit_adv  = commit_ok;
  assign merge       = 1'b0;
  assign enq_ready_o = has_room;
`endif

  assign enq_fire   = enq_valid_i & enq_ready_o & ~flush_i;
  assign alloc      = enq_fire & ~merge;
  assign drain_fire = drain_valid_o & drain_ready_i;
  assign cmt_next   = commit_adv ? cmt_q + PTR_W'(1) : cmt_q;

  // Pointer state; flush rewinds tail to the post-commit cmt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      if (drain_fire) head_q <= head_q + PTR_W'(1);
      cmt_q <= cmt_next;
      if (flush_i)    tail_q <= cmt_next;
      else if (alloc) tail_q <= tail_q + PTR_W'(1);
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_q[tail_q[IDX_W-1:0]] <= '{addr: enq_addr_i, data: enq_data_i, strb: enq_strb_i,
                                    uncached: enq_uncached_i, merge_cnt: '0};
    end
`ifdef SQ_COALESCE_EN
    if (enq_fire && merge) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (enq_strb_i[b]) mem_q[yng_idx].data[8*b +: 8] <= enq_data_i[8*b +: 8];
      end
      mem_q[yng_idx].strb <= yng.strb | enq_strb_i;
    end
    // A merge and a commit-absorb on the same entry cancel out.
    if (enq_fire && merge && !(commit_dec && cmt_idx == yng_idx)) begin
      mem_q[yng_idx].merge_cnt <= yng.merge_cnt + SQ_CNT_W'(1);
    end
    if (commit_dec && !(enq_fire && merge && cmt_idx == yng_idx)) begin
      mem_q[cmt_idx].merge_cnt <= mem_q[cmt_idx].merge_cnt - SQ_CNT_W'(1);
    end
`endif
  end

  assign drain_valid_o    = head_q != cmt_q;
  assign drain_addr_o     = mem_q[head_q[IDX_W-1:0]].addr;
  assign drain_data_o     = mem_q[head_q[IDX_W-1:0]].data;
  assign drain_strb_o     = mem_q[head_q[IDX_W-1:0]].strb;
  assign drain_uncached_o = mem_q[head_q[IDX_W-1:0]].uncached;

  assign count_o = count;
  assign full_o  = count == PTR_W'(SQ_DEPTH);
  assign empty_o = count == '0;

  // Lookup: entries re-ordered by age (k=0 is head) so selection is a simple priority scan.
  logic [SQ_DEPTH-1:0]                 unc_hit;
  logic [STRB_W-1:0][SQ_DEPTH-1:0]     byte_hit;
  logic [STRB_W-1:0][SQ_DEPTH*8-1:0]   byte_data;

  for (genvar k = 0; k < SQ_DEPTH; k++) begin : g_age
    logic [IDX_W-1:0] ri;
    logic             word_hit;
    assign ri       = head_q[IDX_W-1:0] + IDX_W'(k);
    assign word_hit = (PTR_W'(k) < count)
                    & (mem_q[ri].addr[ADDR_W-1:OFF_W] == ld_addr_i[ADDR_W-1:OFF_W]);
    assign unc_hit[k] = word_hit & mem_q[ri].uncached;
    for (genvar b = 0; b < STRB_W; b++) begin : g_byte
      assign byte_hit[b][k]        = word_hit & ~mem_q[ri].uncached & mem_q[ri].strb[b];
      assign byte_data[b][k*8 +: 8] = mem_q[ri].data[8*b +: 8];
    end
  end

  assign ld_conflict_o = |unc_hit;

  for (genvar b = 0; b < STRB_W; b++) begin : g_sel
    sq_fwd_select #(
      .DEPTH (SQ_DEPTH)
    ) u_sel (
      .hit_i  (byte_hit[b]),
      .data_i (byte_data[b]),
      .sel_o  (ld_fwd_mask_o[b]),
      .byte_o (ld_fwd_data_o[8*b +: 8])
    );
  end

endmodule

// File: tb/tb_coalesce_store_queue.sv
// Directed self-checking bench for coalesce_store_queue (default 8 x 32-bit geometry).
module tb_coalesce_store_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_addr = '0;
  logic [31:0] enq_data = '0;
  logic [3:0]  enq_strb = '0;
  logic        enq_uncached = 1'b0;
  logic        commit = 1'b0;
  logic        drain_valid;
  logic        drain_ready = 1'b0;
  logic [31:0] drain_addr, drain_data;
  logic [3:0]  drain_strb;
  logic        drain_uncached;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_mask;
  logic [31:0] ld_data;
  logic        ld_conflict;
  logic        full, empty;
  logic [3:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] held_addr, held_data;

  always #5 clk = ~clk;

  coalesce_store_queue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush),
    .enq_valid_i      (enq_valid),
    .enq_ready_o      (enq_ready),
    .enq_addr_i       (enq_addr),
    .enq_data_i       (enq_data),
    .enq_strb_i       (enq_strb),
    .enq_uncached_i   (enq_uncached),
    .commit_i         (commit),
    .drain_valid_o    (drain_valid),
    .drain_ready_i    (drain_ready),
    .drain_addr_o     (drain_addr),
    .drain_data_o     (drain_data),
    .drain_strb_o     (drain_strb),
    .drain_uncached_o (drain_uncached),
    .ld_addr_i        (ld_addr),
    .ld_fwd_mask_o    (ld_mask),
    .ld_fwd_data_o    (ld_data),
    .ld_conflict_o    (ld_conflict),
    .full_o           (full),
    .empty_o          (empty),
    .count_o          (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic u);
    enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_strb = s; enq_uncached = u;
    tick();
    enq_valid = 1'b0; enq_uncached = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_drain_valid", drain_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_mask", ld_mask, 0);
    chk("rst_conflict", ld_conflict, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill to full with no commits, then retire three and drain them in order
    for (int i = 0; i < 8; i++) enq(32'h100 + 32'(4*i), 32'hD0 + 32'(i), 4'hF, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_enq_ready", enq_ready, 0);
    chk("fill_drain_valid", drain_valid, 0);
    chk("fill_count", count, 8);
    for (int i = 0; i < 3; i++) do_commit();
    drain_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("fill_drain_valid_n", drain_valid, 1);
      chk("fill_drain_addr", drain_addr, 32'h100 + 32'(4*i));
      chk("fill_drain_data", drain_data, 32'hD0 + 32'(i));
      tick();
    end
    drain_ready = 1'b0;
    chk("fill_drain_stop", drain_valid, 0);
    chk("fill_count_after", count, 5);
    do_flush();
    chk("fill_flush_empty", empty, 1);

    // Youngest-byte forwarding across two overlapping stores
    enq(32'h1000, 32'hAABBCCDD, 4'hF, 1'b0);
    ld_addr = 32'h1000;
    enq_valid = 1'b1; enq_addr = 32'h1002; enq_data = 32'h11220000; enq_strb = 4'hC;
    #1;
    chk("fwd_new_invisible_mask", ld_mask, 4'hF);
    chk("fwd_new_invisible_data", ld_data, 32'hAABBCCDD);
    tick();
    enq_valid = 1'b0;
    chk("fwd_mask", ld_mask, 4'hF);
    chk("fwd_data", ld_data, 32'h1122CCDD);
    chk("fwd_conflict", ld_conflict, 0);
    ld_addr = 32'h1004;
    #1;
    chk("fwd_miss_mask", ld_mask, 0);
    chk("fwd_miss_data", ld_data, 0);
    do_flush();

    // Flush together with commit keeps only the committed prefix
    for (int i = 0; i < 5; i++) enq(32'h500 + 32'(4*i), 32'h50 + 32'(i), 4'hF, 1'b0);
    do_commit();
    do_commit();
    flush = 1'b1; commit = 1'b1;
    enq_valid = 1'b1; enq_addr = 32'h700; enq_data = 32'h77; enq_strb = 4'hF;
    tick();
    flush = 1'b0; commit = 1'b0; enq_valid = 1'b0;
    chk("flush_count", count, 3);
    ld_addr = 32'h500;
    drain_ready = 1'b1;
    #1;
    chk("flush_draining_visible", ld_mask, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("flush_drain_addr", drain_addr, 32'h500 + 32'(4*i));
      tick();
    end
    drain_ready = 1'b0;
    chk("flush_empty", empty, 1);
    chk("flush_drain_valid", drain_valid, 0);

    // Uncached store blocks forwarding and raises conflict on its word only
    enq(32'h2000, 32'h12345678, 4'hF, 1'b1);
    ld_addr = 32'h2004;
    #1;
    chk("unc_other_conflict", ld_conflict, 0);
    chk("unc_other_mask", ld_mask, 0);
    ld_addr = 32'h2000;
    #1;
    chk("unc_conflict", ld_conflict, 1);
    chk("unc_mask", ld_mask, 0);
    do_flush();

    // Drain data held under back-pressure, including across a flush
    enq(32'h600, 32'h66, 4'hF, 1'b0);
    enq(32'h604, 32'h67, 4'h3, 1'b0);
    do_commit();
    do_commit();
    held_addr = 32'h600;
    held_data = 32'h66;
    for (int i = 0; i < 4; i++) begin
      flush = (i == 1);
      enq_valid = (i == 1); enq_addr = 32'h800; enq_data = 32'h88; enq_strb = 4'hF;
      tick();
      chk("bp_valid", drain_valid, 1);
      chk("bp_addr", drain_addr, held_addr);
      chk("bp_data", drain_data, held_data);
    end
    flush = 1'b0; enq_valid = 1'b0;
    chk("bp_count", count, 2);
    drain_ready = 1'b1;
    tick();
    chk("bp_second_addr", drain_addr, 32'h604);
    chk("bp_second_strb", drain_strb, 4'h3);
    tick();
    drain_ready = 1'b0;
    chk("bp_empty", empty, 1);

    // Two stores to one word: merged when coalescing, separate entries otherwise
    enq(32'h3000, 32'h0000BEEF, 4'h3, 1'b0);
    enq(32'h3000, 32'hCAFE0000, 4'hC, 1'b0);
`ifdef SQ_COALESCE_EN
    chk("coal_count", count, 1);
    ld_addr = 32'h3000;
    #1;
    chk("coal_fwd_mask", ld_mask, 4'hF);
    chk("coal_fwd_data", ld_data, 32'hCAFEBEEF);
    do_commit();
    chk("coal_first_commit", drain_valid, 0);
    do_commit();
    chk("coal_second_commit", drain_valid, 1);
    chk("coal_strb", drain_strb, 4'hF);
    chk("coal_data", drain_data, 32'hCAFEBEEF);
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
    chk("coal_empty", empty, 1);
`else
    chk("nocoal_count", count, 2);
    do_commit();
    chk("nocoal_first_commit", drain_valid, 1);
    chk("nocoal_strb", drain_strb, 4'h3);
    do_flush();
    chk("nocoal_flush_count", count, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
